memory_stage: RTL and testbench

- Y86-64 pipeline memory stage. It consumes the M-register outputs produced by the execute stage (M_icode, M_valE, M_valA, M_dstE, M_dstM, M_stat, M_cnd).
- It performs the data-memory read or write, owns the byte-addressed data memory array, and drives the W pipeline register consumed by writeback.
- It exports m_valM and m_stat combinationally for forwarding and for pipeline-control exception detection.

---
 rtl/memory_stage.sv | 123 ++++++++++++
 tb/tb_memory_stage.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/memory_stage.sv
// Y86-64 memory stage: classifies the M-register access, owns the byte-addressed
// data memory, exports m_valM/m_stat for forwarding and loads the W register.
module memory_stage #(
  parameter int MEM_BYTES = 1024,
  parameter int ADDR_W    = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        M_stat,
  input  logic [3:0]        M_icode,
  input  logic              M_cnd,
  input  logic [63:0]       M_valE,
  input  logic [63:0]       M_valA,
  input  logic [3:0]        M_dstE,
  input  logic [3:0]        M_dstM,
  input  logic              W_stall,
  input  logic              W_bubble,
  output logic [63:0]       m_valM,
  output logic [1:0]        m_stat,
  output logic              mem_error,
  output logic [1:0]        W_stat,
  output logic [3:0]        W_icode,
  output logic              W_cnd,
  output logic [63:0]       W_valE,
  output logic [63:0]       W_valM,
  output logic [3:0]        W_dstE,
  output logic [3:0]        W_dstM
);

  localparam int IDX_W = $clog2(MEM_BYTES);

  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;
  localparam logic [3:0] R_NONE   = 4'hF;

  localparam logic [1:0] S_AOK = 2'b00;
  localparam logic [1:0] S_ADR = 2'b10;

  // Highest legal start address of an 8-byte access; comparing against this
  // (rather than addr+8 against MEM_BYTES) cannot overflow near 2^64.
  localparam logic [ADDR_W-1:0] MAX_ADDR = ADDR_W'(MEM_BYTES - 8);

  logic [7:0]        mem [MEM_BYTES];

  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] addr;
  logic              addr_ok;
  logic              wr_en;
  logic [IDX_W-1:0]  base_idx;
  logic [IDX_W-1:0]  byte_idx [8];
  logic [63:0]       rd_word;

  always_comb begin
    mem_read  = 1'b0;
    mem_write = 1'b0;
    case (M_icode)
      I_MRMOVQ, I_RET, I_POPQ:    mem_read  = 1'b1;
      I_RMMOVQ, I_CALL, I_PUSHQ:  mem_write = 1'b1;
      default: ;
    endcase
  end

  assign addr      = (M_icode == I_RET || M_icode == I_POPQ) ? ADDR_W'(M_valA) : ADDR_W'(M_valE);
  assign addr_ok   = (addr <= MAX_ADDR);
  assign mem_error = (mem_read | mem_write) & ~addr_ok;
  assign wr_en     = mem_write & addr_ok & (M_stat == S_AOK) & ~rst;
  assign base_idx  = addr[IDX_W-1:0];

  // Little-endian byte lanes; indices only matter when addr_ok holds.
  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_lane
      assign byte_idx[gi]          = base_idx + IDX_W'(gi);
      assign rd_word[gi*8 +: 8]    = mem[byte_idx[gi]];
    end
  endgenerate

  assign m_valM = (mem_read && addr_ok) ? rd_word : 64'd0;
  assign m_stat = (mem_error && M_stat == S_AOK) ? S_ADR : M_stat;

  // Memory contents survive rst; only the write itself is gated by it.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < 8; i++) begin
        mem[byte_idx[i]] <= M_valA[i*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      W_stat  <= S_AOK;
      W_icode <= I_NOP;
      W_cnd   <= 1'b0;
      W_valE  <= 64'd0;
      W_valM  <= 64'd0;
      W_dstE  <= R_NONE;
      W_dstM  <= R_NONE;
    end else if (W_bubble) begin
      W_stat  <= S_AOK;
      W_icode <= I_NOP;
      W_cnd   <= 1'b0;
      W_valE  <= 64'd0;
      W_valM  <= 64'd0;
      W_dstE  <= R_NONE;
      W_dstM  <= R_NONE;
    end else if (!W_stall) begin
      W_stat  <= m_stat;
      W_icode <= M_icode;
      W_cnd   <= M_cnd;
      W_valE  <= M_valE;
      W_valM  <= m_valM;
      W_dstE  <= M_dstE;
      W_dstM  <= M_dstM;
    end
  end

endmodule

// File: tb/tb_memory_stage.sv
// Directed bench for memory_stage: a vector table for the access/status paths
// plus hand sequences for reset, stall and bubble behaviour.
module tb_memory_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [1:0]  M_stat = '0;
  logic [3:0]  M_icode = 4'h1;
  logic        M_cnd = 1'b0;
  logic [63:0] M_valE = '0;
  logic [63:0] M_valA = '0;
  logic [3:0]  M_dstE = 4'hF;
  logic [3:0]  M_dstM = 4'hF;
  logic        W_stall = 1'b0;
  logic        W_bubble = 1'b0;
  logic [63:0] m_valM;
  logic [1:0]  m_stat;
  logic        mem_error;
  logic [1:0]  W_stat;
  logic [3:0]  W_icode;
  logic        W_cnd;
  logic [63:0] W_valE;
  logic [63:0] W_valM;
  logic [3:0]  W_dstE;
  logic [3:0]  W_dstM;

  int pass_cnt = 0;
  int total_cnt = 0;

  memory_stage #(.MEM_BYTES(1024), .ADDR_W(64)) dut (
    .clk(clk), .rst(rst),
    .M_stat(M_stat), .M_icode(M_icode), .M_cnd(M_cnd),
    .M_valE(M_valE), .M_valA(M_valA), .M_dstE(M_dstE), .M_dstM(M_dstM),
    .W_stall(W_stall), .W_bubble(W_bubble),
    .m_valM(m_valM), .m_stat(m_stat), .mem_error(mem_error),
    .W_stat(W_stat), .W_icode(W_icode), .W_cnd(W_cnd),
    .W_valE(W_valE), .W_valM(W_valM), .W_dstE(W_dstE), .W_dstM(W_dstM)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  icode;
    logic [1:0]  stat;
    logic        cnd;
    logic [63:0] valE;
    logic [63:0] valA;
    logic [3:0]  dstE;
    logic [3:0]  dstM;
    logic [63:0] exp_valM;
    logic [1:0]  exp_stat;
    logic        exp_err;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic drive(input logic [3:0] icode, input logic [1:0] stat, input logic cnd,
                       input logic [63:0] valE, input logic [63:0] valA,
                       input logic [3:0] dstE, input logic [3:0] dstM);
    M_icode = icode; M_stat = stat; M_cnd = cnd;
    M_valE = valE; M_valA = valA; M_dstE = dstE; M_dstM = dstM;
  endtask

  task automatic chk_bubble(input string tag);
    chk({tag, " W_icode"}, 64'(W_icode), 64'h1);
    chk({tag, " W_stat"},  64'(W_stat),  64'h0);
    chk({tag, " W_cnd"},   64'(W_cnd),   64'h0);
    chk({tag, " W_valE"},  W_valE,       64'h0);
    chk({tag, " W_valM"},  W_valM,       64'h0);
    chk({tag, " W_dstE"},  64'(W_dstE),  64'hF);
    chk({tag, " W_dstM"},  64'(W_dstM),  64'hF);
  endtask

  initial begin
    //                icode stat cnd valE                    valA                    dE    dM    exp_valM                exp_stat exp_err
    vecs.push_back('{4'h4, 2'd0, 0, 64'h100,                64'h1122334455667788,   4'hF, 4'hF, 64'h0,                  2'd0, 0});
    vecs.push_back('{4'h5, 2'd0, 0, 64'h100,                64'hDEADBEEF,           4'hF, 4'h2, 64'h1122334455667788,   2'd0, 0});
    vecs.push_back('{4'h4, 2'd0, 0, 64'h104,                64'hAABBCCDDEEFF0011,   4'hF, 4'hF, 64'h0,                  2'd0, 0});
    vecs.push_back('{4'h5, 2'd0, 0, 64'h100,                64'h0,                  4'hF, 4'h7, 64'hEEFF001155667788,   2'd0, 0});
    vecs.push_back('{4'h4, 2'd0, 0, 64'h3F8,                64'hCAFEF00D12345678,   4'hF, 4'hF, 64'h0,                  2'd0, 0});
    vecs.push_back('{4'hB, 2'd0, 0, 64'h400,                64'h3F8,                4'h4, 4'h3, 64'hCAFEF00D12345678,   2'd0, 0});
    vecs.push_back('{4'hB, 2'd0, 0, 64'h401,                64'h3F9,                4'h4, 4'h3, 64'h0,                  2'd2, 1});
    vecs.push_back('{4'hB, 2'd0, 0, 64'h4,                  64'hFFFFFFFFFFFFFFFC,   4'h4, 4'h3, 64'h0,                  2'd2, 1});
    vecs.push_back('{4'hA, 2'd0, 0, 64'h400,                64'h55,                 4'h4, 4'hF, 64'h0,                  2'd2, 1});
    vecs.push_back('{4'h4, 2'd0, 0, 64'h200,                64'h0123456789ABCDEF,   4'hF, 4'hF, 64'h0,                  2'd0, 0});
    vecs.push_back('{4'hA, 2'd3, 0, 64'h200,                64'hDEAD,               4'h4, 4'hF, 64'h0,                  2'd3, 0});
    vecs.push_back('{4'h5, 2'd0, 0, 64'h200,                64'h0,                  4'hF, 4'h1, 64'h0123456789ABCDEF,   2'd0, 0});
    vecs.push_back('{4'h5, 2'd1, 0, 64'h500,                64'h0,                  4'hF, 4'h1, 64'h0,                  2'd1, 1});
    vecs.push_back('{4'h8, 2'd0, 0, 64'h1F8,                64'h40,                 4'h4, 4'hF, 64'h0,                  2'd0, 0});
    vecs.push_back('{4'h9, 2'd0, 0, 64'h200,                64'h1F8,                4'h4, 4'hF, 64'h40,                 2'd0, 0});
    vecs.push_back('{4'h6, 2'd0, 1, 64'hFFFFFFFFFFFFFFFF,   64'h3F9,                4'h3, 4'hF, 64'h0,                  2'd0, 0});
    vecs.push_back('{4'h4, 2'd0, 0, 64'h3F9,                64'hFFFFFFFFFFFFFFFF,   4'hF, 4'hF, 64'h0,                  2'd2, 1});
    vecs.push_back('{4'h5, 2'd0, 0, 64'h3F8,                64'h0,                  4'hF, 4'h5, 64'hCAFEF00D12345678,   2'd0, 0});

    // Power-on reset: W must show bubble values without any clock edge.
    #1 rst = 1'b1;
    #1 chk_bubble("por");
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i].icode, vecs[i].stat, vecs[i].cnd, vecs[i].valE, vecs[i].valA,
            vecs[i].dstE, vecs[i].dstM);
      #1;
      chk($sformatf("v%0d m_valM", i),    m_valM,          vecs[i].exp_valM);
      chk($sformatf("v%0d m_stat", i),    64'(m_stat),     64'(vecs[i].exp_stat));
      chk($sformatf("v%0d mem_error", i), 64'(mem_error),  64'(vecs[i].exp_err));
      @(posedge clk);
      #1;
      chk($sformatf("v%0d W_valM", i),  W_valM,          vecs[i].exp_valM);
      chk($sformatf("v%0d W_stat", i),  64'(W_stat),     64'(vecs[i].exp_stat));
      chk($sformatf("v%0d W_icode", i), 64'(W_icode),    64'(vecs[i].icode));
      chk($sformatf("v%0d W_valE", i),  W_valE,          vecs[i].valE);
      chk($sformatf("v%0d W_cnd", i),   64'(W_cnd),      64'(vecs[i].cnd));
      chk($sformatf("v%0d W_dstE", i),  64'(W_dstE),     64'(vecs[i].dstE));
      chk($sformatf("v%0d W_dstM", i),  64'(W_dstM),     64'(vecs[i].dstM));
      $display("vec %0d icode=%h addrE=%h addrA=%h m_valM=%h m_stat=%0d err=%0d",
               i, vecs[i].icode, vecs[i].valE, vecs[i].valA, m_valM, m_stat, mem_error);
    end

    // Reset asserted mid-run alongside a qualifying write: W clears at once, write dropped.
    @(negedge clk);
    drive(4'h4, 2'd0, 1'b1, 64'h300, 64'h1111, 4'h2, 4'h2);
    @(negedge clk);
    drive(4'h4, 2'd0, 1'b1, 64'h300, 64'h2222, 4'h2, 4'h2);
    rst = 1'b1;
    #1 chk_bubble("rst_async");
    @(posedge clk);
    #1 chk_bubble("rst_hold");
    @(negedge clk);
    rst = 1'b0;
    drive(4'h5, 2'd0, 1'b0, 64'h300, 64'h0, 4'hF, 4'h6);
    #1 chk("rst_wr_suppressed m_valM", m_valM, 64'h1111);
    $display("seq reset-during-write: m_valM=%h", m_valM);

    // Stall holds W for two cycles, release loads, stall+bubble gives a bubble.
    @(negedge clk);
    drive(4'h6, 2'd0, 1'b0, 64'h77, 64'h0, 4'h2, 4'hF);
    @(posedge clk);
    #1 chk("pre_stall W_valE", W_valE, 64'h77);
    @(negedge clk);
    drive(4'h6, 2'd0, 1'b1, 64'h5, 64'h0, 4'h3, 4'hF);
    W_stall = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(posedge clk);
      #1;
      chk($sformatf("stall%0d W_valE", c), W_valE,       64'h77);
      chk($sformatf("stall%0d W_dstE", c), 64'(W_dstE),  64'h2);
      chk($sformatf("stall%0d W_cnd", c),  64'(W_cnd),   64'h0);
    end
    @(negedge clk);
    W_stall = 1'b0;
    @(posedge clk);
    #1;
    chk("release W_valE", W_valE,      64'h5);
    chk("release W_dstE", 64'(W_dstE), 64'h3);
    chk("release W_cnd",  64'(W_cnd),  64'h1);
    @(negedge clk);
    W_stall = 1'b1;
    W_bubble = 1'b1;
    @(posedge clk);
    #1 chk_bubble("stall_bubble");
    $display("seq stall/bubble: W_icode=%h W_valE=%h W_dstE=%h", W_icode, W_valE, W_dstE);
    @(negedge clk);
    W_stall = 1'b0;
    W_bubble = 1'b0;

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: simulation did not complete, expected finish");
    $fatal(1, "timeout");
  end

endmodule
